// File: rtl/i2c_target.sv
// I2C target endpoint: address match, register-pointer write and word read via a register-file port.
// Optional: define I2C_TARGET_AUTO_INCREMENT_EN to advance register_address after each burst word.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDRESS           = 7'h11,
  parameter int         NUMBER_OF_REGISTER_BYTES = 1,
  parameter int         NUMBER_OF_DATA_BYTES     = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  scl_in,
  input  logic                                  sda_in,
  output logic                                  sda_oe,
  output logic [8*NUMBER_OF_REGISTER_BYTES-1:0] register_address,
  output logic [8*NUMBER_OF_DATA_BYTES-1:0]     write_data,
  output logic                                  write_valid,
  output logic                                  read_request,
  input  logic [8*NUMBER_OF_DATA_BYTES-1:0]     read_data,
  output logic                                  busy
);
  localparam int RW = 8 * NUMBER_OF_REGISTER_BYTES;
  localparam int DW = 8 * NUMBER_OF_DATA_BYTES;
  localparam logic [1:0] REG_LAST  = 2'(NUMBER_OF_REGISTER_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(NUMBER_OF_DATA_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, ADDRESS, ADDRESS_ACK, REGISTER, REGISTER_ACK, WRITE_DATA,
    WRITE_ACK, READ_LOAD, READ_DATA, READ_ACK, IGNORE
  } state_t;

  function automatic logic [RW-1:0] ptr_advance(input logic [RW-1:0] ptr);
`ifdef I2C_TARGET_AUTO_INCREMENT_EN
    return ptr + RW'(1);
`else
    return ptr;
`endif
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [1:0]      load_cnt_q, load_cnt_d;
  logic [6:0]      addr_q, addr_d;
  logic            rnw_q, rnw_d;
  logic [RW-1:0]   reg_shift_q, reg_shift_d;
  logic [DW-1:0]   data_shift_q, data_shift_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            write_valid_q, write_valid_d;
  logic            read_request_q, read_request_d;
  logic [RW-1:0]   register_address_q, register_address_d;
  logic [DW-1:0]   write_data_q, write_data_d;

  // Stage p0/p1: two-flop synchronizer; stage p2: previous value for edge detection
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  always_ff @(posedge clock) begin
    scl_p0 <= scl_in;
    scl_p1 <= scl_p0;
    scl_p2 <= scl_p1;
    sda_p0 <= sda_in;
    sda_p1 <= sda_p0;
    sda_p2 <= sda_p1;
  end

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign sda_s     = sda_p1;
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_comb begin
    state_d            = state_q;
    bit_cnt_d          = bit_cnt_q;
    byte_cnt_d         = byte_cnt_q;
    load_cnt_d         = load_cnt_q;
    addr_d             = addr_q;
    rnw_d              = rnw_q;
    reg_shift_d        = reg_shift_q;
    data_shift_d       = data_shift_q;
    sda_oe_d           = sda_oe_q;
    busy_d             = busy_q;
    write_valid_d      = 1'b0;
    read_request_d     = 1'b0;
    write_data_d       = write_data_q;
    register_address_d = write_valid_q ? ptr_advance(register_address_q) : register_address_q;

    if (start_det) begin
      state_d   = ADDRESS;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDRESS: if (scl_rise) begin
          addr_d    = {addr_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rnw_d = sda_s;
            if (addr_q == DEVICE_ADDRESS) begin
              state_d = ADDRESS_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        // ACK states: first SCL fall pulls SDA low, the next one releases it and moves on
        ADDRESS_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            if (rnw_q) begin
              state_d        = READ_LOAD;
              read_request_d = 1'b1;
              load_cnt_d     = '0;
            end else begin
              state_d = REGISTER;
            end
          end
        end
        REGISTER: if (scl_rise) begin
          reg_shift_d = {reg_shift_q[RW-2:0], sda_s};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = REGISTER_ACK;
        end
        REGISTER_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q) begin
            if (byte_cnt_q == REG_LAST) begin
              register_address_d = reg_shift_q;
              byte_cnt_d         = '0;
              state_d            = WRITE_DATA;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = REGISTER;
            end
          end
        end
        WRITE_DATA: if (scl_rise) begin
          data_shift_d = {data_shift_q[DW-2:0], sda_s};
          bit_cnt_d    = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = WRITE_ACK;
        end
        WRITE_ACK: begin
          if (scl_rise && byte_cnt_q == DATA_LAST) begin
            write_valid_d = 1'b1;
            write_data_d  = data_shift_q;
          end
          if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) begin
              byte_cnt_d = (byte_cnt_q == DATA_LAST) ? 2'd0 : byte_cnt_q + 2'd1;
              state_d    = WRITE_DATA;
            end
          end
        end
        // read_data is valid two cycles after the read_request strobe
        READ_LOAD: begin
          load_cnt_d = load_cnt_q + 2'd1;
          if (load_cnt_q == 2'd2) begin
            data_shift_d = read_data;
            sda_oe_d     = ~read_data[DW-1];
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            state_d      = READ_DATA;
          end
        end
        READ_DATA: if (scl_fall) begin
          data_shift_d = {data_shift_q[DW-2:0], 1'b0};
          bit_cnt_d    = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = READ_ACK;
          end else begin
            sda_oe_d = ~data_shift_q[DW-2];
          end
        end
        READ_ACK: begin
          if (scl_rise && sda_s) begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            if (byte_cnt_q == DATA_LAST) begin
              register_address_d = ptr_advance(register_address_q);
              read_request_d     = 1'b1;
              load_cnt_d         = '0;
              state_d            = READ_LOAD;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              sda_oe_d   = ~data_shift_q[DW-1];
              state_d    = READ_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      bit_cnt_q          <= '0;
      byte_cnt_q         <= '0;
      load_cnt_q         <= '0;
      sda_oe_q           <= 1'b0;
      busy_q             <= 1'b0;
      write_valid_q      <= 1'b0;
      read_request_q     <= 1'b0;
      register_address_q <= '0;
      write_data_q       <= '0;
    end else begin
      state_q            <= state_d;
      bit_cnt_q          <= bit_cnt_d;
      byte_cnt_q         <= byte_cnt_d;
      load_cnt_q         <= load_cnt_d;
      sda_oe_q           <= sda_oe_d;
      busy_q             <= busy_d;
      write_valid_q      <= write_valid_d;
      read_request_q     <= read_request_d;
      register_address_q <= register_address_d;
      write_data_q       <= write_data_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q       <= addr_d;
    rnw_q        <= rnw_d;
    reg_shift_q  <= reg_shift_d;
    data_shift_q <= data_shift_d;
  end

  assign sda_oe           = sda_oe_q;
  assign busy             = busy_q;
  assign write_valid      = write_valid_q;
  assign read_request     = read_request_q;
  assign register_address = register_address_q;
  assign write_data       = write_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master tasks, register-file responder and a transaction-level model.
module tb_i2c_target;
  localparam logic [6:0] DEV = 7'h11;
  localparam int Q = 6;
`ifdef I2C_TARGET_AUTO_INCREMENT_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       m_scl, m_sda;
  logic       scl_in, sda_in, sda_oe;
  logic [7:0] register_address, write_data, read_data;
  logic       write_valid, read_request, busy;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  always #5 clock = ~clock;

  i2c_target dut (
    .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .register_address(register_address), .write_data(write_data), .write_valid(write_valid),
    .read_request(read_request), .read_data(read_data), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulse_errs = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  logic [7:0] model_mem [256];
  logic [7:0] sys_mem [256];
  logic [7:0] wbuf [4];
  logic [7:0] ptr;
  logic [7:0] got_wr_addr[$], got_wr_data[$], got_rd_addr[$];
  logic [7:0] exp_wr_addr[$], exp_wr_data[$], exp_rd_addr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register-file side: records strobes, presents read_data only in the capture cycle
  initial begin : responder
    int rd_cnt;
    logic [7:0] rd_addr;
    logic wv_prev, rr_prev;
    rd_cnt = 0; rd_addr = 0; wv_prev = 0; rr_prev = 0;
    read_data = 8'h00;
    forever begin
      @(negedge clock);
      if (write_valid) begin
        got_wr_addr.push_back(register_address);
        got_wr_data.push_back(write_data);
        sys_mem[register_address] = write_data;
      end
      if (read_request) begin
        got_rd_addr.push_back(register_address);
        rd_addr = register_address;
        read_data = ~sys_mem[register_address];
        rd_cnt = 1;
      end else if (rd_cnt == 1) begin
        rd_cnt = 2;
      end else if (rd_cnt == 2) begin
        read_data = sys_mem[rd_addr];
        rd_cnt = 3;
      end else if (rd_cnt == 3) begin
        read_data = ~sys_mem[rd_addr];
        rd_cnt = 0;
      end
      if ((write_valid && wv_prev) || (read_request && rr_prev) || (write_valid && read_request))
        pulse_errs++;
      wv_prev = write_valid;
      rr_prev = read_request;
      if (sda_oe) oe_cycles++;
      if (busy) busy_cycles++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    m_sda = 1; m_scl = 1; tick(Q);
    m_sda = 0; tick(Q);
    m_scl = 0; tick(Q);
  endtask

  task automatic bus_rep_start();
    m_sda = 1; tick(Q);
    m_scl = 1; tick(Q);
    m_sda = 0; tick(Q);
    m_scl = 0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 0; tick(Q);
    m_scl = 1; tick(Q);
    m_sda = 1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; tick(Q);
    m_scl = 1; tick(2 * Q);
    m_scl = 0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1; tick(Q);
    m_scl = 1; tick(Q);
    b = sda_in; tick(Q);
    m_scl = 0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic do_write(input logic [6:0] dv, input logic [7:0] ra, input int n);
    logic ack, match;
    int oe0, busy0;
    match = (dv == DEV);
    oe0 = oe_cycles;
    busy0 = busy_cycles;
    bus_start();
    put_byte({dv, 1'b0}, ack);
    check("wr_addr_ack", 32'(ack), 32'(match));
    if (match) check("wr_busy", 32'(busy), 32'd1);
    put_byte(ra, ack);
    check("wr_reg_ack", 32'(ack), 32'(match));
    if (match) ptr = ra;
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], ack);
      check("wr_data_ack", 32'(ack), 32'(match));
      if (match) begin
        exp_wr_addr.push_back(ptr);
        exp_wr_data.push_back(wbuf[i]);
        model_mem[ptr] = wbuf[i];
        ptr = ptr + 8'(INC);
      end
    end
    bus_stop();
    check("wr_busy_end", 32'(busy), 32'd0);
    if (!match) begin
      check("nomatch_oe", 32'(oe_cycles - oe0), 32'd0);
      check("nomatch_busy", 32'(busy_cycles - busy0), 32'd0);
    end
  endtask

  task automatic do_read(input logic [7:0] ra, input int n);
    logic ack;
    logic [7:0] v;
    bus_start();
    put_byte({DEV, 1'b0}, ack);
    check("rd_waddr_ack", 32'(ack), 32'd1);
    put_byte(ra, ack);
    check("rd_reg_ack", 32'(ack), 32'd1);
    ptr = ra;
    bus_rep_start();
    put_byte({DEV, 1'b1}, ack);
    check("rd_raddr_ack", 32'(ack), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_rd_addr.push_back(ptr);
      get_byte(v, i != n - 1);
      check("rd_data", 32'(v), 32'(model_mem[ptr]));
      if (i != n - 1) ptr = ptr + 8'(INC);
    end
    bus_stop();
    check("rd_busy_end", 32'(busy), 32'd0);
  endtask

  task automatic flush_checks();
    tick(4);
    check("wr_count", 32'(got_wr_addr.size()), 32'(exp_wr_addr.size()));
    while (got_wr_addr.size() > 0 && exp_wr_addr.size() > 0) begin
      check("wr_addr", 32'(got_wr_addr.pop_front()), 32'(exp_wr_addr.pop_front()));
      check("wr_value", 32'(got_wr_data.pop_front()), 32'(exp_wr_data.pop_front()));
    end
    check("rd_req_count", 32'(got_rd_addr.size()), 32'(exp_rd_addr.size()));
    while (got_rd_addr.size() > 0 && exp_rd_addr.size() > 0)
      check("rd_req_addr", 32'(got_rd_addr.pop_front()), 32'(exp_rd_addr.pop_front()));
    got_wr_addr.delete(); got_wr_data.delete(); got_rd_addr.delete();
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
    check("pulse_shape", 32'(pulse_errs), 32'd0);
    check("reg_pointer", 32'(register_address), 32'(ptr));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic ack, seen;
    logic [7:0] ra;
    logic [6:0] dv;
    int kind, n;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'($urandom);
      sys_mem[i] = model_mem[i];
    end
    m_scl = 1; m_sda = 1; reset = 1; ptr = 0;
    tick(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_addr", 32'(register_address), 32'd0);
    check("rst_write_data", 32'(write_data), 32'd0);
    check("rst_write_valid", 32'(write_valid), 32'd0);
    check("rst_read_request", 32'(read_request), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 0;
    tick(5);

    wbuf[0] = 8'hA5;
    do_write(DEV, 8'h3C, 1);
    flush_checks();

    model_mem[8'h10] = 8'h5A; sys_mem[8'h10] = 8'h5A;
    do_read(8'h10, 1);
    flush_checks();

    wbuf[0] = 8'h77; wbuf[1] = 8'h88;
    do_write(7'h5A, 8'h20, 2);
    flush_checks();

    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
    do_write(DEV, 8'hFE, 3);
    flush_checks();

    // stray STOP in the middle of the register byte
    bus_start();
    put_byte({DEV, 1'b0}, ack);
    check("stray_addr_ack", 32'(ack), 32'd1);
    put_bit(1); put_bit(0); put_bit(1); put_bit(1);
    bus_stop();
    check("stray_busy", 32'(busy), 32'd0);
    flush_checks();

    // reset while the target is driving a 0 data bit
    model_mem[8'h40] = 8'h3C; sys_mem[8'h40] = 8'h3C;
    bus_start();
    put_byte({DEV, 1'b0}, ack);
    check("rst_rd_waddr_ack", 32'(ack), 32'd1);
    put_byte(8'h40, ack);
    check("rst_rd_reg_ack", 32'(ack), 32'd1);
    bus_rep_start();
    put_byte({DEV, 1'b1}, ack);
    check("rst_rd_raddr_ack", 32'(ack), 32'd1);
    exp_rd_addr.push_back(8'h40);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (sda_oe) seen = 1;
    end
    check("rst_drive_seen", 32'(seen), 32'd1);
    reset = 1;
    @(negedge clock);
    check("rst_mid_oe", 32'(sda_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    reset = 0;
    ptr = 0;
    tick(Q);
    bus_stop();
    flush_checks();
    wbuf[0] = 8'hC3;
    do_write(DEV, 8'h41, 1);
    flush_checks();
    do_read(8'h41, 1);
    flush_checks();

    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 2);
      ra = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      if (kind == 0) begin
        do_write(DEV, ra, n);
      end else if (kind == 1) begin
        do_read(ra, n);
      end else begin
        dv = 7'($urandom);
        if (dv == DEV) dv = DEV ^ 7'h01;
        do_write(dv, ra, n);
      end
      flush_checks();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Synthesizable I2C target (slave) endpoint: the responder for the team's `i2c_master`. It samples the shared open-drain SCL/SDA lines, matches a 7-bit device address, then either writes a register-addressed data word to a simple register-file port or fetches a word from that port and shifts it out. It sits behind the board pull-ups alongside other targets; SDA is driven only low, through `sda_oe`.

## Interface
- `DEVICE_ADDRESS`, 7'h11, 7-bit address this target acknowledges.
- `NUMBER_OF_REGISTER_BYTES`, 1, register-address bytes per transfer (1–4).
- `NUMBER_OF_DATA_BYTES`, 1, bytes per data word (1–4).
- `clock`  in  1  system clock, ≥ 12× SCL frequency.
- `reset`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  SCL line level (asynchronous).
- `sda_in`  in  1  SDA line level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `register_address`  out  8·NUMBER_OF_REGISTER_BYTES  current register pointer.
- `write_data`  out  8·NUMBER_OF_DATA_BYTES  word received from the master.
- `write_valid`  out  1  one-cycle strobe; `write_data`/`register_address` valid.
- `read_request`  out  1  one-cycle strobe; system must present `read_data`.
- `read_data`  in  8·NUMBER_OF_DATA_BYTES  word to send; sampled 2 cycles after `read_request`.
- `busy`  out  1  high from address match until STOP or NACK-abort.

## Operation
- `scl_in`/`sda_in` pass through 2-flop synchronizers; edges detected on synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are honoured in every state; START (incl. repeated) → ADDRESS, STOP → IDLE.
- Bits sampled on SCL rising edge, MSB first; `sda_oe` changes only on the SCL falling edge.
- States: IDLE, ADDRESS, ADDRESS_ACK, REGISTER, REGISTER_ACK, WRITE_DATA, WRITE_ACK, READ_LOAD, READ_DATA, READ_ACK, IGNORE.
- ADDRESS: shift 8 bits (7 address + R/W). Mismatch → IGNORE (no drive until next START/STOP). Match → ADDRESS_ACK, drive ACK for one SCL period, `busy`=1.
- After ADDRESS_ACK: W → REGISTER; R → READ_LOAD.
- REGISTER: receive NUMBER_OF_REGISTER_BYTES bytes MSB-byte first, ACK each; loads `register_address` after last byte, then WRITE_DATA.
- WRITE_DATA: receive NUMBER_OF_DATA_BYTES bytes, ACK each; after the last byte's ACK-bit sample, pulse `write_valid` one cycle, then pointer update (see Configuration), then WRITE_DATA again.
- READ_LOAD: pulse `read_request` on the SCL falling edge ending the ACK; capture `read_data` exactly 2 cycles later into the shift register; first bit driven immediately → READ_DATA.
- READ_DATA: shift out 8·NUMBER_OF_DATA_BYTES bits; `sda_oe` = ~bit. Between bytes of a multi-byte word, release SDA for the master ACK bit.
- READ_ACK after final byte: master ACK (SDA low) → pointer update, READ_LOAD; master NACK → release SDA, IGNORE until STOP/START, `busy` cleared.
- Repeated START after REGISTER keeps `register_address` (standard register-read sequence).

## Timing
- Reset values: `sda_oe`=0, `register_address`=0, `write_data`=0, `write_valid`=0, `read_request`=0, `busy`=0, state IDLE.
- Reset mid-transfer: SDA released in the cycle following reset; no strobes until a new START.
- Line-to-decision latency: 3 clocks (2 sync + edge register).
- `write_valid` and `read_request` are never high in the same cycle; each is exactly 1 cycle.
- Required SCL low time ≥ 6 clocks (read_data capture + setup); SCL high ≥ 4 clocks.
- Pointer wraps modulo 2^(8·NUMBER_OF_REGISTER_BYTES); 0xFF+1 = 0x00 for one byte.
- START and STOP detected in the same SCL-high period: last one wins.

## Configuration
- `I2C_TARGET_AUTO_INCREMENT_EN` defined: `register_address` increments by 1 after every `write_valid` and after every master-ACKed read word (burst access).
- Undefined: `register_address` changes only in REGISTER; bursts repeatedly access the same register.

## Test plan
- Write: master writes 0xA5 to reg 0x3C at address 0x11 → one `write_valid`, `write_data`=0xA5, `register_address`=0x3C, three ACKs on SDA.
- Read: reg 0x10 then repeated START read, system returns 0x5A → `read_request` once, master receives 0x5A, NACK → `busy` falls at STOP.
- Address mismatch: master addresses 0x5A → `sda_oe` stays 0 for whole transfer, no strobes, `busy`=0.
- Burst with macro defined: write 0x01,0x02,0x03 from reg 0xFE → strobes at 0xFE,0xFF,0x00; without macro all at 0xFE.
- Reset mid-read while driving a 0 bit → `sda_oe`=0 next cycle, next transaction completes normally.
- Stray STOP during REGISTER byte → IDLE, `register_address` unchanged, no `write_valid`.
